mul_fxp_pipe: RTL and testbench

MUL_FXP_PIPE -- requirements
Module: mul_fxp_pipe

---
 rtl/mul_fxp_pkg.sv | 10 +
 rtl/mul_fxp_lane.sv | 74 +++++++
 rtl/mul_fxp_pipe.sv | 81 ++++++++
 tb/tb_mul_fxp_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_fxp_pkg.sv
// Shared definitions for the pipelined fixed-point multiplier.
package mul_fxp_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2
    } rmode_t;

endpackage

// File: rtl/mul_fxp_lane.sv
// One multiplier lane: S2 forms the full signed product, S3 rounds,
// detects overflow and saturates or wraps into the result register.
module mul_fxp_lane
    import mul_fxp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FBITS = 8,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       rmode,
    output logic [WIDTH-1:0] val,
    output logic             ovf
);

    localparam logic signed [2*WIDTH:0] HALF = (2*WIDTH+1)'(1) << (FBITS-1);
    localparam logic signed [2*WIDTH:0] ONE  = (2*WIDTH+1)'(1);

    rmode_t                    rm;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH:0]   ext;
    logic signed [2*WIDTH:0]   inc;
    logic signed [2*WIDTH:0]   sum;
    logic signed [2*WIDTH:0]   rounded;
    logic [WIDTH+1:0]          top;
    logic                      in_range;
    logic [WIDTH-1:0]          sat_val;
    logic [WIDTH-1:0]          res;

    assign rm = rmode_t'(rmode);

    always_ff @(posedge clk) begin
        if (en) begin
            prod <= (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
        end
    end

    // One extra bit of headroom so the rounding increment can never wrap.
    assign ext = {prod[2*WIDTH-1], prod};

    // Half-even: add half-1 plus the kept LSB, so exact ties only carry
    // into an odd LSB while every other fraction rounds to nearest.
    always_comb begin
        inc = '0;
        case (rm)
            RND_TRUNC:   inc = '0;
            RND_HALF_UP: inc = HALF;
            default:     inc = HALF - ONE + {{(2*WIDTH){1'b0}}, prod[FBITS]};
        endcase
    end

    assign sum      = ext + inc;
    assign rounded  = sum >>> FBITS;
    assign top      = rounded[2*WIDTH:WIDTH-1];
    assign in_range = (&top) | ~(|top);
    assign sat_val  = rounded[2*WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
    assign res      = (in_range || SAT == 0) ? rounded[WIDTH-1:0] : sat_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            val <= res;
            ovf <= ~in_range;
        end
    end

endmodule

// File: rtl/mul_fxp_pipe.sv
// Three-stage pipelined signed fixed-point multiplier with LANES lanes
// sharing a single valid/ready handshake.
module mul_fxp_pipe
    import mul_fxp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FBITS = 8,
    parameter int LANES = 1,
    parameter int SAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [1:0]             rmode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] val,
    output logic [LANES-1:0]       ovf
);

    if (FBITS < 1 || FBITS >= WIDTH) begin : g_bad_fbits
        $error("mul_fxp_pipe: FBITS must satisfy 1 <= FBITS < WIDTH");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Valid never depends on ready; the whole pipe advances together on
    // en, so in_ready is high whenever the output slot is empty or draining.
    logic                   en;
    logic                   v1;
    logic                   v2;
    logic [LANES*WIDTH-1:0] a1;
    logic [LANES*WIDTH-1:0] b1;
    rmode_t                 rm1;
    rmode_t                 rm2;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
        end
    end

    // Mode 3 is folded into half-even at capture so lanes see only legal codes.
    always_ff @(posedge clk) begin
        if (en) begin
            a1  <= a;
            b1  <= b;
            rm1 <= (rmode == 2'd3) ? RND_HALF_EVEN : rmode_t'(rmode);
            rm2 <= rm1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mul_fxp_lane #(
            .WIDTH (WIDTH),
            .FBITS (FBITS),
            .SAT   (SAT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .a     (a1[i*WIDTH +: WIDTH]),
            .b     (b1[i*WIDTH +: WIDTH]),
            .rmode (rm2),
            .val   (val[i*WIDTH +: WIDTH]),
            .ovf   (ovf[i])
        );
    end

endmodule

// File: tb/tb_mul_fxp_pipe.sv
// Scoreboard bench for mul_fxp_pipe (WIDTH=8, FBITS=4, LANES=2): one
// saturating and one wrapping instance share stimulus.
module tb_mul_fxp_pipe;

    localparam int W = 8;
    localparam int L = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           out_ready;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [1:0]     rmode;
    logic           in_ready;
    logic           out_valid;
    logic [L*W-1:0] val;
    logic [L-1:0]   ovf;
    logic           w_in_ready;
    logic           w_out_valid;
    logic [L*W-1:0] w_val;
    logic [L-1:0]   w_ovf;

    always #5 clk = ~clk;

    mul_fxp_pipe #(.WIDTH(W), .FBITS(4), .LANES(L), .SAT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rmode(rmode), .out_valid(out_valid),
        .out_ready(out_ready), .val(val), .ovf(ovf)
    );

    mul_fxp_pipe #(.WIDTH(W), .FBITS(4), .LANES(L), .SAT(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .rmode(rmode), .out_valid(w_out_valid),
        .out_ready(out_ready), .val(w_val), .ovf(w_ovf)
    );

    typedef struct {
        logic [7:0] a0, b0, a1, b1;
        logic [1:0] rm;
        logic [7:0] v0, v1, w0, w1;
        logic [1:0] ovf;
    } vec_t;

    vec_t        tab[$];
    logic [33:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          sent = 0;
    int          received = 0;
    logic [33:0] m_e;
    int          m_l;
    int          m_ac;
    logic [L*W-1:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic add(input logic [7:0] a0, b0, a1, b1, input logic [1:0] rm,
                       input logic [7:0] v0, v1, w0, w1, input logic [1:0] o);
        vec_t v;
        v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.rm = rm;
        v.v0 = v0; v.v1 = v1; v.w0 = w0; v.w1 = w1; v.ovf = o;
        tab.push_back(v);
    endtask

    // Drive one transaction and hold it until accepted; returns on the
    // falling edge after the accepting edge.
    task automatic send(input vec_t v, input bit lat_chk);
        int t = 0;
        a = {v.a1, v.a0};
        b = {v.b1, v.b0};
        rmode = v.rm;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back({v.v1, v.v0, v.w1, v.w0, v.ovf});
        lat_q.push_back(lat_chk ? 3 : -1);
        acc_q.push_back(cyc);
        sent++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n);
        int t = 0;
        while (exp_q.size() != 0 && t < n) begin
            @(negedge clk);
            t++;
        end
        #3;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete(); lat_q.delete(); acc_q.delete();
        end
        chk("received_count", 32'(received), 32'(sent));
    endtask

    // Monitor: a result is consumed on an edge where out_valid && out_ready.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got val=%h, required no output", val);
            end else begin
                m_e  = exp_q.pop_front();
                m_l  = lat_q.pop_front();
                m_ac = acc_q.pop_front();
                received++;
                chk("val_sat",    32'(val),         32'(m_e[33:18]));
                chk("ovf_sat",    32'(ovf),         32'(m_e[1:0]));
                chk("valid_wrap", 32'(w_out_valid), 32'd1);
                chk("val_wrap",   32'(w_val),       32'(m_e[17:2]));
                chk("ovf_wrap",   32'(w_ovf),       32'(m_e[1:0]));
                if (m_l >= 0) chk("latency", 32'(cyc - m_ac), 32'(m_l));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; rmode = 2'd0;

        //   a0    b0    a1    b1    rm     v0    v1    w0    w1    ovf
        add(8'h11,8'h08,8'h11,8'h18,2'd0, 8'h08,8'h19,8'h08,8'h19,2'b00);
        add(8'h11,8'h08,8'h11,8'h18,2'd1, 8'h09,8'h1A,8'h09,8'h1A,2'b00);
        add(8'h11,8'h08,8'h11,8'h18,2'd2, 8'h08,8'h1A,8'h08,8'h1A,2'b00);
        add(8'h11,8'h08,8'h11,8'h18,2'd3, 8'h08,8'h1A,8'h08,8'h1A,2'b00);
        add(8'hEF,8'h08,8'h7F,8'h7F,2'd0, 8'hF7,8'h7F,8'hF7,8'hF0,2'b10);
        add(8'hEF,8'h08,8'h80,8'h80,2'd1, 8'hF8,8'h7F,8'hF8,8'h00,2'b10);
        add(8'hEF,8'h08,8'h80,8'h10,2'd2, 8'hF8,8'h80,8'hF8,8'h80,2'b00);
        add(8'h18,8'h18,8'h7F,8'h20,2'd0, 8'h24,8'h7F,8'h24,8'hFE,2'b10);
        add(8'h80,8'h7F,8'h01,8'h01,2'd0, 8'h80,8'h00,8'h08,8'h00,2'b01);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_val",       32'(val),       32'd0);
        chk("reset_ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, back to back.
        foreach (tab[i]) send(tab[i], 1'b1);
        wait_drain(50);

        // Stream six, then stall with the pipe full and a seventh waiting.
        @(negedge clk);
        for (int i = 0; i < 6; i++) send(tab[i], i < 3);
        out_ready = 1'b0;
        a = {tab[6].a1, tab[6].a0};
        b = {tab[6].b1, tab[6].b0};
        rmode = tab[6].rm;
        in_valid = 1'b1;
        #1;
        held = val;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_val",       32'(val),       32'(held));
            @(negedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 6; i < 9; i++) send(tab[i], 1'b1);
        wait_drain(50);

        // Reset with two transactions in S1/S2; neither may emerge.
        @(negedge clk);
        send(tab[4], 1'b0);
        send(tab[5], 1'b0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_val",       32'(val),       32'd0);
        chk("midrst_ovf",       32'(ovf),       32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) begin
            void'(exp_q.pop_back());
            void'(lat_q.pop_back());
            void'(acc_q.pop_back());
            sent--;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk); #1;
            chk("no_stale_output", 32'(out_valid), 32'd0);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
